// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch stage for the 8-bit datapath.
// Drives a synchronous instruction memory and hands instr/pc/valid to decode with zero-bubble branches.
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 9,
  parameter int LUT_DEPTH = 32,
  localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall_i,
  input  logic               branch_taken,
  input  logic               br_rel,
  input  logic [IDX_W-1:0]   br_idx,
  input  logic               halt_i,
  input  logic               lut_we,
  input  logic [IDX_W-1:0]   lut_waddr,
  input  logic [PC_W-1:0]    lut_wdata,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               instr_valid,
  output logic               done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        pc_o_q, pc_o_d;
  logic                   vld_q, vld_d;
  logic                   done_q, done_d;
  logic [PC_W-1:0]        lut_q [LUT_DEPTH];

  logic                   accept;
  logic signed [PC_W-1:0] rel_off;
  logic [PC_W-1:0]        target;

  assign accept  = vld_q & ~stall_i;
  assign rel_off = {{(PC_W-IDX_W){br_idx[IDX_W-1]}}, br_idx};
  // Table read is combinational from the registered array, so a same-cycle write is not yet visible.
  assign target  = br_rel ? pc_o_q + rel_off : lut_q[br_idx];

  assign instr_o     = imem_rdata;
  assign pc_o        = pc_o_q;
  assign instr_valid = vld_q;
  assign done_o      = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_RUN;
      S_RUN:          if (accept && halt_i) state_d = S_HALT;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_addr = '0;
    pc_d      = pc_q;
    pc_o_d    = pc_o_q;
    vld_d     = vld_q;
    done_d    = done_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d   = PC_ONE;
          pc_o_d = '0;
          vld_d  = 1'b1;
          done_d = 1'b0;
        end else if (state_q == S_HALT) begin
          imem_addr = pc_o_q;
        end
      end
      S_RUN: begin
        if (!accept) begin
          imem_addr = pc_o_q;
        end else if (halt_i) begin
          imem_addr = pc_o_q;
          vld_d     = 1'b0;
          done_d    = 1'b1;
        end else if (branch_taken) begin
          imem_addr = target;
          pc_d      = target + PC_ONE;
          pc_o_d    = target;
        end else begin
          imem_addr = pc_q;
          pc_d      = pc_q + PC_ONE;
          pc_o_d    = pc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= '0;
      pc_o_q <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pc_o_q <= pc_o_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory holds instr[k] = k+3, outputs sampled on the falling edge.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n, start, stall_i, branch_taken, br_rel, halt_i, lut_we;
  logic [4:0] br_idx, lut_waddr;
  logic [9:0] lut_wdata, imem_addr, pc_o;
  logic [8:0] imem_rdata, instr_o;
  logic       instr_valid, done_o;

  logic [8:0] mem [1024];
  int vectors = 0;
  int miscompares = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall_i(stall_i),
    .branch_taken(branch_taken), .br_rel(br_rel), .br_idx(br_idx), .halt_i(halt_i),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_o(instr_o),
    .pc_o(pc_o), .instr_valid(instr_valid), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    vectors++; if (pc_o !== 10'h000) begin miscompares++; $display("FAIL rst_pc got %h want 000", pc_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done_o); end
    vectors++; if (imem_addr !== 10'h000) begin miscompares++; $display("FAIL rst_addr got %h want 000", imem_addr); end
    step();
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %b want 0", instr_valid); end
  endtask

  task automatic test_sequential();
    logic [9:0] exp_pc;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL start_valid got %b want 1", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      exp_pc = 10'(k);
      vectors++; if (pc_o !== exp_pc) begin miscompares++; $display("FAIL seq_pc[%0d] got %h want %h", k, pc_o, exp_pc); end
      vectors++; if (instr_o !== 9'(k + 3)) begin miscompares++; $display("FAIL seq_instr[%0d] got %h want %h", k, instr_o, 9'(k + 3)); end
      if (k < 2) step();
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    branch_taken = 1'b1;
    halt_i = 1'b1;
    br_rel = 1'b1;
    br_idx = 5'd5;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++; if (pc_o !== 10'h002) begin miscompares++; $display("FAIL stall_pc[%0d] got %h want 002", c, pc_o); end
      vectors++; if (instr_o !== 9'h005) begin miscompares++; $display("FAIL stall_instr[%0d] got %h want 005", c, instr_o); end
      vectors++; if (instr_valid !== 1'b1 || done_o !== 1'b0) begin miscompares++; $display("FAIL stall_flags[%0d] got v=%b d=%b want v=1 d=0", c, instr_valid, done_o); end
    end
    stall_i = 1'b0;
    branch_taken = 1'b0;
    halt_i = 1'b0;
    br_rel = 1'b0;
    step();
    vectors++; if (pc_o !== 10'h003) begin miscompares++; $display("FAIL unstall_pc got %h want 003", pc_o); end
    vectors++; if (instr_o !== 9'h006) begin miscompares++; $display("FAIL unstall_instr got %h want 006", instr_o); end
  endtask

  task automatic test_branch_lut();
    lut_we = 1'b1; lut_waddr = 5'd4; lut_wdata = 10'h040;
    step();
    lut_we = 1'b0;
    step();
    vectors++; if (pc_o !== 10'h005) begin miscompares++; $display("FAIL pre_br_pc got %h want 005", pc_o); end
    branch_taken = 1'b1; br_rel = 1'b0; br_idx = 5'd4;
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_o !== 10'h040) begin miscompares++; $display("FAIL lut_br_pc got %h want 040", pc_o); end
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL lut_br_valid got %b want 1", instr_valid); end
    vectors++; if (instr_o !== 9'h043) begin miscompares++; $display("FAIL lut_br_instr got %h want 043", instr_o); end
    step();
    vectors++; if (pc_o !== 10'h041) begin miscompares++; $display("FAIL lut_br_next got %h want 041", pc_o); end
    // write and branch-read the same entry together: old target wins
    lut_we = 1'b1; lut_waddr = 5'd4; lut_wdata = 10'h080;
    branch_taken = 1'b1; br_idx = 5'd4;
    step();
    lut_we = 1'b0;
    vectors++; if (pc_o !== 10'h040) begin miscompares++; $display("FAIL lut_old_pc got %h want 040", pc_o); end
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_o !== 10'h080) begin miscompares++; $display("FAIL lut_new_pc got %h want 080", pc_o); end
    vectors++; if (instr_o !== 9'h083) begin miscompares++; $display("FAIL lut_new_instr got %h want 083", instr_o); end
  endtask

  task automatic test_branch_rel();
    lut_we = 1'b1; lut_waddr = 5'd1; lut_wdata = 10'h010;
    step();
    lut_we = 1'b0;
    branch_taken = 1'b1; br_rel = 1'b0; br_idx = 5'd1;
    step();
    vectors++; if (pc_o !== 10'h010) begin miscompares++; $display("FAIL rel_setup_pc got %h want 010", pc_o); end
    br_rel = 1'b1; br_idx = 5'b11101;
    step();
    vectors++; if (pc_o !== 10'h00D) begin miscompares++; $display("FAIL rel_neg_pc got %h want 00d", pc_o); end
    vectors++; if (instr_o !== 9'h010) begin miscompares++; $display("FAIL rel_neg_instr got %h want 010", instr_o); end
    br_idx = 5'b01111;
    step();
    branch_taken = 1'b0; br_rel = 1'b0;
    vectors++; if (pc_o !== 10'h01C) begin miscompares++; $display("FAIL rel_pos_pc got %h want 01c", pc_o); end
    vectors++; if (instr_o !== 9'h01F) begin miscompares++; $display("FAIL rel_pos_instr got %h want 01f", instr_o); end
  endtask

  task automatic test_wrap();
    lut_we = 1'b1; lut_waddr = 5'd2; lut_wdata = 10'h3FF;
    step();
    lut_we = 1'b0;
    branch_taken = 1'b1; br_rel = 1'b0; br_idx = 5'd2;
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_o !== 10'h3FF) begin miscompares++; $display("FAIL wrap_top_pc got %h want 3ff", pc_o); end
    vectors++; if (instr_o !== 9'h002) begin miscompares++; $display("FAIL wrap_top_instr got %h want 002", instr_o); end
    step();
    vectors++; if (pc_o !== 10'h000) begin miscompares++; $display("FAIL wrap_inc_pc got %h want 000", pc_o); end
    vectors++; if (instr_o !== 9'h003) begin miscompares++; $display("FAIL wrap_inc_instr got %h want 003", instr_o); end
    branch_taken = 1'b1; br_rel = 1'b1; br_idx = 5'b11111;
    step();
    branch_taken = 1'b0; br_rel = 1'b0;
    vectors++; if (pc_o !== 10'h3FF) begin miscompares++; $display("FAIL wrap_rel_pc got %h want 3ff", pc_o); end
    step();
    vectors++; if (pc_o !== 10'h000) begin miscompares++; $display("FAIL wrap_rel_next got %h want 000", pc_o); end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 7; k++) step();
    vectors++; if (pc_o !== 10'h007) begin miscompares++; $display("FAIL pre_halt_pc got %h want 007", pc_o); end
    halt_i = 1'b1; branch_taken = 1'b1; br_rel = 1'b0; br_idx = 5'd4;
    step();
    halt_i = 1'b0; branch_taken = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid got %b want 0", instr_valid); end
    vectors++; if (done_o !== 1'b1) begin miscompares++; $display("FAIL halt_done got %b want 1", done_o); end
    vectors++; if (pc_o !== 10'h007) begin miscompares++; $display("FAIL halt_pc got %h want 007", pc_o); end
    vectors++; if (imem_addr !== 10'h007) begin miscompares++; $display("FAIL halt_addr got %h want 007", imem_addr); end
    step();
    vectors++; if (done_o !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_hold got d=%b v=%b want d=1 v=0", done_o, instr_valid); end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL restart_done got %b want 0", done_o); end
    vectors++; if (pc_o !== 10'h000) begin miscompares++; $display("FAIL restart_pc got %h want 000", pc_o); end
    vectors++; if (instr_valid !== 1'b1 || instr_o !== 9'h003) begin miscompares++; $display("FAIL restart_instr got v=%b i=%h want v=1 i=003", instr_valid, instr_o); end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (pc_o !== 10'h002) begin miscompares++; $display("FAIL run_start_pc got %h want 002", pc_o); end
  endtask

  task automatic test_reset_midrun();
    lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h020;
    step();
    lut_we = 1'b0;
    branch_taken = 1'b1; br_rel = 1'b0; br_idx = 5'd3;
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_o !== 10'h020) begin miscompares++; $display("FAIL mid_setup_pc got %h want 020", pc_o); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", instr_valid); end
    vectors++; if (pc_o !== 10'h000) begin miscompares++; $display("FAIL mid_rst_pc got %h want 000", pc_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done got %b want 0", done_o); end
    start = 1'b1;
    step();
    start = 1'b0;
    branch_taken = 1'b1; br_rel = 1'b0; br_idx = 5'd4;
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_o !== 10'h000) begin miscompares++; $display("FAIL mid_rst_lut got %h want 000", pc_o); end
    step();
    vectors++; if (pc_o !== 10'h001) begin miscompares++; $display("FAIL mid_rst_next got %h want 001", pc_o); end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 9'(k + 3);
    rst_n = 1'b0; start = 1'b0; stall_i = 1'b0; branch_taken = 1'b0; br_rel = 1'b0;
    br_idx = '0; halt_i = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_lut();
    test_branch_rel();
    test_wrap();
    test_halt();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
